// File: rtl/d_cache_2way_wt_if.sv
// sram-like req/addr_ok/data_ok bus shared by the core side and the memory side of the data cache.
// master issues requests; slave accepts them and returns data.
interface d_cache_2way_wt_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/d_cache_2way_wt.sv
// d_cache_2way_wt: 2-way set-associative, write-through, no-write-allocate data cache with per-set LRU.
// Optional: define DCACHE_CRITICAL_WORD_FIRST_EN to refill from the requested word and answer the core early.
module d_cache_2way_wt #(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              no_cache,
  d_cache_2way_wt_if.slave  cpu,
  d_cache_2way_wt_if.master mem
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << (OFFSET_WIDTH - 2);
  localparam int WORD_W    = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
  localparam logic [WORD_W-1:0] WORD_MASK = WORD_W'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, REFILL, RESP, UNC_RD, MEM_WR} state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [3:0]  m;
    logic [31:0] bm;
    case (size)
      2'd0:    m = 4'b0001 << lane;
      2'd1:    m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{m[b]}};
    return (old_w & ~bm) | (new_w & bm);
  endfunction

  state_t                  state;
  logic                    mem_req;
  logic                    victim_way;
  logic [TAG_WIDTH-1:0]    fill_tag;
  logic [INDEX_WIDTH-1:0]  fill_idx;
  logic [WORD_W-1:0]       fill_start;
  logic [WORD_W-1:0]       beat;

  logic [1:0][SETS-1:0]    valid;
  logic [SETS-1:0]         lru;
  logic [TAG_WIDTH-1:0]    tag_arr  [2][SETS];
  logic [31:0]             data_arr [2][SETS][WORDS];

  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_idx;
  logic [WORD_W-1:0]       req_word;
  logic [WORD_W-1:0]       start_word;
  logic [WORD_W-1:0]       fill_word;
  logic [1:0]              way_hit;
  logic                    hit;
  logic                    hit_way;
  logic                    read_hit;
  logic                    victim;
  logic                    last_beat;
  logic [31:0]             hit_word;
  logic [31:0]             wr_merged;
  logic                    cpu_ok;
  logic [31:0]             cpu_rdata;

  assign req_tag  = cpu.addr[31 -: TAG_WIDTH];
  assign req_idx  = cpu.addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word = (OFFSET_WIDTH > 2) ? cpu.addr[2 +: WORD_W] : '0;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  assign start_word = req_word;
`else
  assign start_word = '0;
`endif

  always_comb begin
    way_hit = '0;
    for (int w = 0; w < 2; w++)
      way_hit[w] = valid[w][req_idx] && (tag_arr[w][req_idx] == req_tag);
  end

  assign hit       = cpu.req && !no_cache && (|way_hit);
  assign hit_way   = way_hit[1];
  assign read_hit  = hit && !cpu.wr;
  assign victim    = !valid[0][req_idx] ? 1'b0 : (!valid[1][req_idx] ? 1'b1 : lru[req_idx]);
  assign hit_word  = data_arr[hit_way][req_idx][req_word];
  assign wr_merged = byte_merge(hit_word, cpu.wdata, cpu.size, cpu.addr[1:0]);
  assign fill_word = (fill_start + beat) & WORD_MASK;
  assign last_beat = (beat == WORD_MASK);

  // Control: FSM, valid and LRU state, memory request strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      valid      <= '0;
      lru        <= '0;
      victim_way <= 1'b0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      fill_start <= '0;
      beat       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_hit) begin
            lru[req_idx] <= ~hit_way;
          end else if (cpu.req) begin
            mem_req <= 1'b1;
            if (cpu.wr) begin
              state <= MEM_WR;
            end else if (no_cache) begin
              state <= UNC_RD;
            end else begin
              state      <= REFILL;
              victim_way <= victim;
              fill_tag   <= req_tag;
              fill_idx   <= req_idx;
              fill_start <= start_word;
              beat       <= '0;
            end
          end
        end
        REFILL: begin
          if (mem.addr_ok) mem_req <= 1'b0;
          // data_ok may coincide with addr_ok; it decides the next request
          if (mem.data_ok) begin
            if (last_beat) begin
              mem_req                   <= 1'b0;
              valid[victim_way][fill_idx] <= 1'b1;
              lru[fill_idx]             <= ~victim_way;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
              state <= IDLE;
`else
              state <= RESP;
`endif
            end else begin
              mem_req <= 1'b1;
              beat    <= beat + 1'b1;
            end
          end
        end
        RESP: state <= IDLE;
        UNC_RD, MEM_WR: begin
          if (mem.addr_ok) mem_req <= 1'b0;
          if (mem.data_ok) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (state == MEM_WR && hit) lru[req_idx] <= ~hit_way;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage: tag and data arrays carry no reset
  always_ff @(posedge clk) begin
    if (state == REFILL && mem.data_ok) begin
      data_arr[victim_way][fill_idx][fill_word] <= mem.rdata;
      if (last_beat) tag_arr[victim_way][fill_idx] <= fill_tag;
    end
    if (state == MEM_WR && mem.data_ok && hit)
      data_arr[hit_way][req_idx][req_word] <= wr_merged;
  end

  always_comb begin
    cpu_ok    = 1'b0;
    cpu_rdata = hit_word;
    case (state)
      IDLE:   cpu_ok = read_hit;
      RESP: begin
        cpu_ok    = 1'b1;
        cpu_rdata = data_arr[victim_way][fill_idx][req_word];
      end
      UNC_RD: begin
        cpu_ok    = mem.data_ok;
        cpu_rdata = mem.rdata;
      end
      MEM_WR: cpu_ok = mem.data_ok;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
      REFILL: begin
        cpu_ok    = mem.data_ok && (beat == '0);
        cpu_rdata = mem.rdata;
      end
`endif
      default: cpu_ok = 1'b0;
    endcase
  end

  assign cpu.addr_ok = cpu_ok;
  assign cpu.data_ok = cpu_ok;
  assign cpu.rdata   = cpu_rdata;

  assign mem.req   = mem_req;
  assign mem.wr    = (state == MEM_WR);
  assign mem.size  = (state == REFILL) ? 2'd2 : cpu.size;
  assign mem.addr  = (state == REFILL)
                   ? ({fill_tag, fill_idx, {OFFSET_WIDTH{1'b0}}} | (32'(fill_word) << 2))
                   : cpu.addr;
  assign mem.wdata = cpu.wdata;

endmodule

// File: tb/tb_d_cache_2way_wt.sv
// Directed bench for d_cache_2way_wt: core driver, sram-like memory responder, hand-computed expectations.
`timescale 1ns/1ps
module tb_d_cache_2way_wt;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic no_cache = 1'b0;

  d_cache_2way_wt_if cpu_if ();
  d_cache_2way_wt_if mem_if ();

  d_cache_2way_wt dut (
    .clk      (clk),
    .rst      (rst),
    .no_cache (no_cache),
    .cpu      (cpu_if),
    .mem      (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
  } txn_t;

  int          total = 0;
  int          bad   = 0;
  txn_t        log_q [$];
  logic [31:0] mem_store [logic [31:0]];
  int          rd_done = 0;
  logic        fast = 1'b0;
  logic        pend = 1'b0;
  int          wait_cnt = 0;
  logic        pend_wr;
  logic [1:0]  pend_size;
  logic [31:0] pend_addr;
  logic [31:0] pend_wdata;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem_store.exists(wa)) return mem_store[wa];
    return 32'hD000_0000 | wa;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [3:0]  m;
    logic [31:0] bm;
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    m = (sz == 2'd0) ? (4'b0001 << a[1:0]) : (sz == 2'd1) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{m[b]}};
    mem_store[wa] = (mem_rd(wa) & ~bm) | (wd & bm);
  endtask

  task automatic finish_txn();
    mem_if.data_ok = 1'b1;
    if (pend_wr) mem_wr(pend_addr, pend_size, pend_wdata);
    else begin
      mem_if.rdata = mem_rd(pend_addr);
      rd_done++;
    end
    pend = 1'b0;
  endtask

  // memory responder: addr_ok on the cycle req is seen, data_ok two cycles later or at once in fast mode
  always @(negedge clk) begin
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
    if (!rst) begin
      pend = 1'b0;
    end else if (pend) begin
      if (wait_cnt == 0) finish_txn();
      else wait_cnt--;
    end else if (mem_if.req) begin
      mem_if.addr_ok = 1'b1;
      pend_wr    = mem_if.wr;
      pend_size  = mem_if.size;
      pend_addr  = mem_if.addr;
      pend_wdata = mem_if.wdata;
      log_q.push_back('{addr: mem_if.addr, wr: mem_if.wr, size: mem_if.size});
      pend = 1'b1;
      if (fast) finish_txn();
      else wait_cnt = 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic nc,
                        output logic [31:0] rd, output int lat);
    @(negedge clk);
    log_q.delete();
    cpu_if.req   = 1'b1;
    cpu_if.wr    = w;
    cpu_if.size  = sz;
    cpu_if.addr  = a;
    cpu_if.wdata = wd;
    no_cache     = nc;
    rd  = 'x;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (cpu_if.data_ok) begin
        rd  = cpu_if.addr_ok ? cpu_if.rdata : 32'hBAD0_0A0C;
        lat = i;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cpu_if.req = 1'b0;
    no_cache   = 1'b0;
  endtask

  task automatic check_fill(input string tag, input logic [31:0] base);
    check({tag, "_nreq"}, 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_addr%0d", tag, i), (i < log_q.size()) ? log_q[i].addr : 32'hFFFF_FFFF,
            base + 32'(4 * i));
      check($sformatf("%s_kind%0d", tag, i), (i < log_q.size()) ? {29'd0, log_q[i].wr, log_q[i].size} : 32'hF,
            32'h2);
    end
  endtask

  task automatic rd_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    access(1'b0, 2'd2, a, 32'h0, 1'b0, rd, lat);
    check({tag, "_data"}, rd, exp);
    check({tag, "_lat"}, 32'(lat), 32'd0);
    check({tag, "_nreq"}, 32'(log_q.size()), 32'd0);
  endtask

  task automatic rd_fill(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    access(1'b0, 2'd2, a, 32'h0, 1'b0, rd, lat);
    check({tag, "_data"}, rd, exp);
    check_fill(tag, {a[31:4], 4'h0});
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    int          lat;
    access(1'b1, sz, a, wd, 1'b0, rd, lat);
    check({tag, "_done"}, 32'(lat >= 0), 32'd1);
    check({tag, "_nreq"}, 32'(log_q.size()), 32'd1);
    check({tag, "_addr"}, (log_q.size() > 0) ? log_q[0].addr : 32'hFFFF_FFFF, a);
    check({tag, "_kind"}, (log_q.size() > 0) ? {29'd0, log_q[0].wr, log_q[0].size} : 32'hF, {29'd0, 1'b1, sz});
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    cpu_if.req   = 1'b0;
    cpu_if.wr    = 1'b0;
    cpu_if.size  = 2'd0;
    cpu_if.addr  = 32'h0;
    cpu_if.wdata = 32'h0;
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
    mem_if.rdata   = 32'h0;
    mem_store[32'h0000_1000] = 32'h1122_3344;

    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_if.req}, 32'd0);
    check("rst_addr_ok", {31'd0, cpu_if.addr_ok}, 32'd0);
    check("rst_data_ok", {31'd0, cpu_if.data_ok}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // first miss fills the whole line from word 0, then the same word hits
    rd_fill("fill1004", 32'h0000_1004, 32'hD000_1004);
    rd_hit("hit1004", 32'h0000_1004, 32'hD000_1004);
    rd_hit("hit100c", 32'h0000_100C, 32'hD000_100C);

    // second line in set 0 with addr_ok/data_ok arriving together
    fast = 1'b1;
    rd_fill("fill9000", 32'h0000_9000, 32'hD000_9000);
    fast = 1'b0;
    rd_hit("hit1000", 32'h0000_1000, 32'h1122_3344);
    rd_hit("hit9008", 32'h0000_9008, 32'hD000_9008);

    // touching 0x1000 makes the 0x9000 line the victim for 0x11000
    rd_hit("touch1000", 32'h0000_1000, 32'h1122_3344);
    rd_fill("fill11000", 32'h0001_1000, 32'hD001_1000);
    rd_hit("kept1000", 32'h0000_1000, 32'h1122_3344);
    rd_fill("evict9000", 32'h0000_9000, 32'hD000_9000);

    // byte and upper-half stores that hit are merged into the line
    fast = 1'b1;
    store("sb1001", 2'd0, 32'h0000_1001, 32'h0000_AA00);
    fast = 1'b0;
    rd_hit("after_sb", 32'h0000_1000, 32'h1122_AA44);
    store("sh100e", 2'd1, 32'h0000_100E, 32'hBEEF_0000);
    rd_hit("after_sh", 32'h0000_100C, 32'hBEEF_100C);

    // write miss does not allocate; the next read refills with the written word
    store("sw5000", 2'd2, 32'h0000_5000, 32'hCAFE_F00D);
    rd_fill("fill5000", 32'h0000_5000, 32'hCAFE_F00D);

    // uncached read goes to memory only and leaves LRU alone (0x11000 must evict the 0x1000 line)
    mem_store[32'h0000_1000] = 32'h7777_7777;
    access(1'b0, 2'd2, 32'h0000_1000, 32'h0, 1'b1, rd, lat);
    check("nc_data", rd, 32'h7777_7777);
    check("nc_nreq", 32'(log_q.size()), 32'd1);
    check("nc_kind", (log_q.size() > 0) ? {29'd0, log_q[0].wr, log_q[0].size} : 32'hF, 32'h2);
    check("nc_addr", (log_q.size() > 0) ? log_q[0].addr : 32'hFFFF_FFFF, 32'h0000_1000);
    rd_fill("nc_fill11000", 32'h0001_1000, 32'hD001_1000);
    rd_hit("nc_hit5000", 32'h0000_5004, 32'hD000_5004);
    rd_fill("nc_fill1000", 32'h0000_1000, 32'h7777_7777);

    // reset while the third refill word is being requested
    @(negedge clk);
    log_q.delete();
    rd_done = 0;
    cpu_if.req  = 1'b1;
    cpu_if.wr   = 1'b0;
    cpu_if.size = 2'd2;
    cpu_if.addr = 32'h0000_2000;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (rd_done >= 2) break;
    end
    check("mid_words", 32'(rd_done), 32'd2);
    @(posedge clk);
    #2;
    check("mid_req_before", {31'd0, mem_if.req}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, mem_if.req}, 32'd0);
    check("mid_rst_addr_ok", {31'd0, cpu_if.addr_ok}, 32'd0);
    check("mid_rst_data_ok", {31'd0, cpu_if.data_ok}, 32'd0);
    @(negedge clk);
    cpu_if.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd_fill("refill2000", 32'h0000_2000, 32'hD000_2000);
    rd_fill("refill5000", 32'h0000_5004, 32'hD000_5004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_cache_2way_wt.md
Name: d_cache_2way_wt

Overview:
- 2-way set-associative, write-through, no-write-allocate data cache with parametrised multi-word lines.
- Sits between the MIPS core data port and the AXI bridge, using the same sram-like req/addr_ok/data_ok handshake on both sides.
- Successor to the direct-mapped, one-word-line data cache. Adds associativity with per-set LRU, multi-word line refill, and a byte-masked write-hit merge.

Parameters:
- INDEX_WIDTH, 7, set index bits; SETS = 2^INDEX_WIDTH.
- OFFSET_WIDTH, 4, line byte-offset bits (>=2); WORDS = 2^(OFFSET_WIDTH-2) words per line.
- TAG_WIDTH is derived as 32-INDEX_WIDTH-OFFSET_WIDTH. It is a localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- no_cache  in  1  current access is uncached; bypasses lookup, fill and LRU.
- cpu_data_req  in  1  core request; held with addr/wr/size/wdata stable until cpu_data_data_ok.
- cpu_data_wr  in  1  1 = store.
- cpu_data_size  in  2  0 = byte, 1 = half, 2 = word.
- cpu_data_addr  in  32  byte address.
- cpu_data_wdata  in  32  store data, lane-aligned.
- cpu_data_rdata  out  32  load data; valid only when cpu_data_data_ok = 1.
- cpu_data_addr_ok  out  1  request accepted.
- cpu_data_data_ok  out  1  request complete.
- cache_data_req  out  1  memory request.
- cache_data_wr  out  1  memory write.
- cache_data_size  out  2  memory size.
- cache_data_addr  out  32  memory address.
- cache_data_wdata  out  32  memory write data.
- cache_data_rdata  in  32  memory read data.
- cache_data_addr_ok  in  1  memory address accepted.
- cache_data_data_ok  in  1  memory data done.

Behaviour:
- Reset (rst = 0, asynchronous):
  - all valid bits and LRU bits cleared; FSM to IDLE.
  - cache_data_req = 0, cpu_data_addr_ok = 0, cpu_data_data_ok = 0.
  - Tag/data arrays are not reset.
  - Reset during REFILL leaves the line invalid.
- Lookup: both ways are compared in parallel. hit = cpu_data_req & ~no_cache & (valid_w & tag_w == tag) for either way. Both ways matching cannot occur.
- FSM states: IDLE, REFILL, RESP, UNC_RD, MEM_WR.
- IDLE transitions:
  - read hit: cpu_data_addr_ok = cpu_data_data_ok = 1 combinationally in the same cycle; rdata = hit word; stay in IDLE.
  - cached read miss -> REFILL.
  - no_cache read -> UNC_RD.
  - any write -> MEM_WR.
- Miss and write completion: for misses and writes, cpu_data_addr_ok and cpu_data_data_ok pulse together, for one cycle, at completion.
- REFILL:
  - WORDS sequential memory reads, size = 2, address {tag, index, word_cnt, 2'b00}.
  - cache_data_req is held from entry until addr_ok. After addr_ok it is 0 until data_ok. The next word is requested in the cycle after data_ok.
  - Each returned word is written into the victim way's line buffer.
  - After the last data_ok: valid = 1, tag written, LRU points to the other way, FSM -> RESP.
- Victim selection: the first invalid way (way0 preferred); otherwise the way named by the LRU bit.
- RESP: one cycle; addr_ok = data_ok = 1; rdata is the requested word from the filled line; -> IDLE.
- UNC_RD:
  - one memory read with the core's size and address.
  - cpu_data_addr_ok = data_ok = cache_data_data_ok; rdata = cache_data_rdata.
  - -> IDLE on data_ok.
- MEM_WR:
  - one memory write with the core's size, address and wdata; completion on cache_data_data_ok.
  - In that same cycle, if the access was a cached hit, the hit word is merged using the byte mask and the LRU bit is updated.
  - Write miss: no allocation and no LRU change. no_cache write: no cache update.
  - -> IDLE.
- Byte mask:
  - size 0: one-hot on addr[1:0].
  - size 1: 4'b0011 if addr[1] = 0, else 4'b1100.
  - size 2: 4'b1111.
  - new = old & ~M | wdata & M, with M = bytewise expansion of the mask.
- LRU: 1 bit per set; on a read hit or write hit it points to the way not accessed.
- Outstanding requests: one at a time. A new cpu_data_req is not accepted outside IDLE. Memory-side data_ok arriving in the same cycle as addr_ok is legal and must be handled.

Optional Feature:
- DCACHE_CRITICAL_WORD_FIRST_EN defined:
  - refill starts at the requested word and wraps modulo WORDS.
  - FSM goes IDLE -> REFILL, then completes the core read in the cycle the first word's data_ok arrives (rdata = cache_data_rdata) and finishes the line silently.
  - A new request is still blocked until the refill ends.
- Undefined: refill always starts at word 0 and the core completes in RESP.

Test Plan:
- Reset, read 0x0000_1004 -> 4 memory reads at 0x1000, 0x1004, 0x1008, 0x100C; RESP returns the word from 0x1004. Re-read -> data_ok in the same cycle as req, no memory request.
- Fill 0x0000_1000 and 0x0000_9000 (same set) -> both hit. Read 0x1000, then fill 0x0001_1000 -> the 0x9000 line is evicted and 0x1000 still hits.
- After filling 0x1000 with 0x11223344: sb 0xAA to 0x1001 -> memory write of size 0 at 0x1001; subsequent read returns 0x1122AA44.
- sw to 0x0000_5000 (miss) -> one memory write only; following read of 0x5000 performs a refill.
- no_cache read of a cached address -> single memory read of size 2, returned data from memory, cache and LRU unchanged.
- Assert rst low mid-REFILL after 2 words -> outputs drop to 0 immediately; re-read performs a full 4-word refill.
